// File: rtl/pcie_phy_pkg.sv
// Shared PHY-side types: AXIS user sideband layout and the ordered-set arbiter state.
package pcie_phy_pkg;

  typedef struct packed {
    logic [1:0] sync_hdr;
    logic       os_start;
    logic       os_end;
  } phy_user_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  localparam logic ARB_MODE_RR    = 1'b0;
  localparam logic ARB_MODE_FIXED = 1'b1;

endpackage

// File: rtl/ltssm_rr_arb.sv
// Combinational winner select: first requester at or after the pointer, or the
// lowest requester when mode selects fixed priority.
module ltssm_rr_arb
  import pcie_phy_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               mode,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               valid
);

  localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

  logic [IDX_W-1:0] base;
  logic [IDX_W:0]   sum;

  // NOTE: every output gets a default before the loop so no path leaves a latch.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    sum       = '0;
    base      = (mode == ARB_MODE_FIXED) ? '0 : ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, base} + (IDX_W+1)'(i);
      if (sum >= NUM_REQ_W) sum = sum - NUM_REQ_W;
      if (!valid && req[sum[IDX_W-1:0]]) begin
        valid                  = 1'b1;
        grant[sum[IDX_W-1:0]]  = 1'b1;
        grant_idx              = sum[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/ltssm_os_arbiter.sv
// Packet-atomic arbiter merging LTSSM ordered-set AXIS streams toward the PHY TX.
// Define LTSSM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module ltssm_os_arbiter
  import pcie_phy_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int USER_WIDTH = $bits(phy_user_t)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  s_axis_tdata_i,
  input  logic [NUM_REQ-1:0][KEEP_WIDTH-1:0]  s_axis_tkeep_i,
  input  logic [NUM_REQ-1:0]                  s_axis_tvalid_i,
  input  logic [NUM_REQ-1:0]                  s_axis_tlast_i,
  input  logic [NUM_REQ-1:0][USER_WIDTH-1:0]  s_axis_tuser_i,
  output logic [NUM_REQ-1:0]                  s_axis_tready_o,
  output logic [DATA_WIDTH-1:0]               m_axis_tdata_o,
  output logic [KEEP_WIDTH-1:0]               m_axis_tkeep_o,
  output logic                                m_axis_tvalid_o,
  output logic                                m_axis_tlast_o,
  output logic [USER_WIDTH-1:0]               m_axis_tuser_o,
  input  logic                                m_axis_tready_i,
  output logic [NUM_REQ-1:0]                  grant_o,
  output logic                                busy_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef LTSSM_ARB_FIXED_PRIO_EN
  localparam logic ARB_MODE = ARB_MODE_FIXED;
`else
  localparam logic ARB_MODE = ARB_MODE_RR;
`endif

  arb_state_e         state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   gidx_q;
  logic [IDX_W-1:0]   ptr_inc;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] win_grant;
  logic [IDX_W-1:0]   win_idx;
  logic               win_valid;
  logic               m_valid_q;
  logic               accept;
  logic               accept_last;

  logic [DATA_WIDTH-1:0] m_data_q;
  logic [KEEP_WIDTH-1:0] m_keep_q;
  logic                  m_last_q;
  logic [USER_WIDTH-1:0] m_user_q;

  ltssm_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req       (s_axis_tvalid_i),
    .ptr       (ptr_q),
    .mode      (ARB_MODE),
    .grant     (win_grant),
    .grant_idx (win_idx),
    .valid     (win_valid)
  );

  // Only the owner sees ready, and only when the output slot is free or draining.
  always_comb begin
    s_axis_tready_o = '0;
    if (state_q == ST_BUSY) s_axis_tready_o[gidx_q] = !m_valid_q || m_axis_tready_i;
  end

  assign accept      = (state_q == ST_BUSY) && s_axis_tvalid_i[gidx_q] && s_axis_tready_o[gidx_q];
  assign accept_last = accept && s_axis_tlast_i[gidx_q];
  assign ptr_inc     = (gidx_q == IDX_W'(NUM_REQ-1)) ? '0 : gidx_q + 1'b1;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      gidx_q    <= '0;
      grant_q   <= '0;
      m_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_valid) begin
            grant_q <= win_grant;
            gidx_q  <= win_idx;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (accept_last) begin
            grant_q <= '0;
            state_q <= ST_IDLE;
            ptr_q   <= (ARB_MODE == ARB_MODE_FIXED) ? '0 : ptr_inc;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (accept)               m_valid_q <= 1'b1;
      else if (m_axis_tready_i) m_valid_q <= 1'b0;
    end
  end

  // NOTE: payload flops carry no reset; they are qualified by m_axis_tvalid_o.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      m_data_q <= s_axis_tdata_i[gidx_q];
      m_keep_q <= s_axis_tkeep_i[gidx_q];
      m_last_q <= s_axis_tlast_i[gidx_q];
      m_user_q <= s_axis_tuser_i[gidx_q];
    end
  end

  assign m_axis_tdata_o  = m_data_q;
  assign m_axis_tkeep_o  = m_keep_q;
  assign m_axis_tlast_o  = m_last_q;
  assign m_axis_tuser_o  = m_user_q;
  assign m_axis_tvalid_o = m_valid_q;
  assign grant_o         = grant_q;
  assign busy_o          = (state_q == ST_BUSY);

endmodule

// File: tb/tb_ltssm_os_arbiter.sv
// Directed bench for ltssm_os_arbiter; expected orders follow LTSSM_ARB_FIXED_PRIO_EN when defined.
module tb_ltssm_os_arbiter;

  localparam int UW = $bits(pcie_phy_pkg::phy_user_t);

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  logic [3:0][31:0]   s_tdata;
  logic [3:0][3:0]    s_tkeep;
  logic [3:0]         s_tvalid;
  logic [3:0]         s_tlast;
  logic [3:0][UW-1:0] s_tuser;
  logic [3:0]         s_tready;
  logic [31:0]        m_data;
  logic [3:0]         m_keep;
  logic               m_valid;
  logic               m_last;
  logic [UW-1:0]      m_user;
  logic               m_ready = 1'b1;
  logic [3:0]         grant;
  logic               busy;

  logic [31:0]   src_data  [4];
  logic          src_valid [4];
  logic          src_last  [4];
  logic [3:0]    src_keep  [4];
  logic [UW-1:0] src_user  [4];

  int n_checks = 0;
  int n_pass   = 0;

  logic [32:0] mon_q [$];
  logic        prev_held = 1'b0;
  logic [31:0] prev_data;
  int          held_viol = 0;

  ltssm_os_arbiter dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .s_axis_tdata_i  (s_tdata),
    .s_axis_tkeep_i  (s_tkeep),
    .s_axis_tvalid_i (s_tvalid),
    .s_axis_tlast_i  (s_tlast),
    .s_axis_tuser_i  (s_tuser),
    .s_axis_tready_o (s_tready),
    .m_axis_tdata_o  (m_data),
    .m_axis_tkeep_o  (m_keep),
    .m_axis_tvalid_o (m_valid),
    .m_axis_tlast_o  (m_last),
    .m_axis_tuser_o  (m_user),
    .m_axis_tready_i (m_ready),
    .grant_o         (grant),
    .busy_o          (busy)
  );

  always #5 clk_i = ~clk_i;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      s_tdata[i]  = src_data[i];
      s_tvalid[i] = src_valid[i];
      s_tlast[i]  = src_last[i];
      s_tkeep[i]  = src_keep[i];
      s_tuser[i]  = src_user[i];
    end
  end

  // Output handshakes and held-beat stability, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (!rst_i && m_valid && m_ready) mon_q.push_back({m_last, m_data});
    if (prev_held && (!m_valid || m_data != prev_data)) held_viol++;
    prev_held = !rst_i && m_valid && !m_ready;
    prev_data = m_data;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    cyc();
    cyc();
    rst_i = 1'b0;
  endtask

  // Presents one packet from source s, holding each beat until the DUT accepts it.
  task automatic send_pkt(input int s, input logic [31:0] base, input int n,
                          input int gap_after, input int gap_len);
    for (int b = 0; b < n; b++) begin
      int  budget;
      bit  acc;
      if (b == gap_after) begin
        src_valid[s] = 1'b0;
        repeat (gap_len) cyc();
      end
      src_valid[s] = 1'b1;
      src_data[s]  = base + 32'(b);
      src_last[s]  = (b == n - 1);
      budget = 0;
      acc    = 1'b0;
      while (!acc && budget < 200) begin
        @(negedge clk_i);
        if (s_tready[s]) acc = 1'b1;
        @(posedge clk_i);
        #1;
        budget++;
      end
      if (!acc) begin
        n_checks++;
        $display("FAIL send_timeout src%0d beat%0d: no ready within 200 cycles", s, b);
      end
    end
    src_valid[s] = 1'b0;
    src_last[s]  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst_i = 1'b1;
    cyc();
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (grant !== 4'b0000) $display("FAIL rst_grant: got %b want 0000", grant); else n_pass++;
    n_checks++; if (m_valid !== 1'b0) $display("FAIL rst_mvalid: got %b want 0", m_valid); else n_pass++;
    n_checks++; if (s_tready !== 4'b0000) $display("FAIL rst_ready: got %b want 0000", s_tready); else n_pass++;
    rst_i = 1'b0;
  endtask

  task automatic test_single_source();
    src_valid[1] = 1'b1;
    src_data[1]  = 32'hA0;
    src_last[1]  = 1'b0;
    #1;
    n_checks++; if (s_tready !== 4'b0000) $display("FAIL idle_bubble_ready: got %b want 0000", s_tready); else n_pass++;
    cyc();
    n_checks++; if (grant !== 4'b0010) $display("FAIL single_grant: got %b want 0010", grant); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else n_pass++;
    n_checks++; if (m_valid !== 1'b0) $display("FAIL single_no_early_beat: got %b want 0", m_valid); else n_pass++;
    for (int b = 0; b < 4; b++) begin
      cyc();
      n_checks++; if (m_valid !== 1'b1) $display("FAIL single_valid b%0d: got %b want 1", b, m_valid); else n_pass++;
      n_checks++; if (m_data !== 32'hA0 + 32'(b)) $display("FAIL single_data b%0d: got %h want %h", b, m_data, 32'hA0 + 32'(b)); else n_pass++;
      n_checks++; if (m_last !== (b == 3)) $display("FAIL single_last b%0d: got %b want %b", b, m_last, (b == 3)); else n_pass++;
      if (b == 0) begin
        n_checks++; if (m_keep !== 4'h7) $display("FAIL single_keep: got %h want 7", m_keep); else n_pass++;
        n_checks++; if (m_user !== UW'(10)) $display("FAIL single_user: got %h want %h", m_user, UW'(10)); else n_pass++;
      end
      if (b < 3) begin
        src_data[1] = 32'hA1 + 32'(b);
        src_last[1] = (b == 2);
      end else begin
        src_valid[1] = 1'b0;
        src_last[1]  = 1'b0;
      end
    end
    n_checks++; if (busy !== 1'b0) $display("FAIL single_busy_drop: got %b want 0", busy); else n_pass++;
    n_checks++; if (grant !== 4'b0000) $display("FAIL single_grant_clear: got %b want 0000", grant); else n_pass++;
    cyc();
    n_checks++; if (m_valid !== 1'b0) $display("FAIL single_drain: got %b want 0", m_valid); else n_pass++;
  endtask

  task automatic test_arbitration();
    logic [32:0] exp_q [8];
`ifdef LTSSM_ARB_FIXED_PRIO_EN
    exp_q = '{{1'b0, 32'h00}, {1'b1, 32'h01}, {1'b0, 32'h10}, {1'b1, 32'h11},
              {1'b0, 32'h20}, {1'b1, 32'h21}, {1'b0, 32'h30}, {1'b1, 32'h31}};
`else
    exp_q = '{{1'b0, 32'h00}, {1'b1, 32'h01}, {1'b0, 32'h20}, {1'b1, 32'h21},
              {1'b0, 32'h10}, {1'b1, 32'h11}, {1'b0, 32'h30}, {1'b1, 32'h31}};
`endif
    do_reset();
    mon_q.delete();
    fork
      begin
        send_pkt(0, 32'h00, 2, -1, 0);
        send_pkt(0, 32'h10, 2, -1, 0);
      end
      begin
        send_pkt(2, 32'h20, 2, -1, 0);
        send_pkt(2, 32'h30, 2, -1, 0);
      end
    join
    repeat (2) cyc();
    n_checks++; if (mon_q.size() !== 8) $display("FAIL arb_count: got %0d want 8", mon_q.size()); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      if (i < mon_q.size()) begin
        n_checks++; if (mon_q[i] !== exp_q[i]) $display("FAIL arb_order[%0d]: got %h want %h", i, mon_q[i], exp_q[i]); else n_pass++;
      end
    end
  endtask

  task automatic test_packet_atomic();
    int bad;
    int waited;
    bad = 0;
    mon_q.delete();
    fork
      send_pkt(3, 32'h40, 4, 2, 5);
      begin
        cyc();
        send_pkt(0, 32'h50, 1, -1, 0);
      end
      begin
        waited = 0;
        while (grant !== 4'b1000 && waited < 20) begin
          @(negedge clk_i);
          waited++;
        end
        n_checks++; if (grant !== 4'b1000) $display("FAIL atomic_grant3: got %b want 1000", grant); else n_pass++;
        for (int k = 0; k < 8; k++) begin
          @(negedge clk_i);
          if (grant !== 4'b1000 || s_tready[0] !== 1'b0) bad++;
        end
      end
    join
    repeat (2) cyc();
    n_checks++; if (bad !== 0) $display("FAIL atomic_hold: got %0d bad cycles want 0", bad); else n_pass++;
    n_checks++; if (mon_q.size() !== 5) $display("FAIL atomic_count: got %0d want 5", mon_q.size()); else n_pass++;
    if (mon_q.size() == 5) begin
      n_checks++; if (mon_q[3] !== {1'b1, 32'h43}) $display("FAIL atomic_src3_last: got %h want 143", mon_q[3]); else n_pass++;
      n_checks++; if (mon_q[4] !== {1'b1, 32'h50}) $display("FAIL atomic_src0_after: got %h want 150", mon_q[4]); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    bit done;
    done = 1'b0;
    held_viol = 0;
    mon_q.delete();
    fork
      begin
        send_pkt(1, 32'h60, 4, -1, 0);
        done = 1'b1;
      end
      begin
        while (!done) begin
          cyc();
          m_ready = ~m_ready;
        end
      end
    join
    m_ready = 1'b1;
    repeat (3) cyc();
    n_checks++; if (held_viol !== 0) $display("FAIL bp_held_beat: got %0d violations want 0", held_viol); else n_pass++;
    n_checks++; if (mon_q.size() !== 4) $display("FAIL bp_count: got %0d want 4", mon_q.size()); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      if (i < mon_q.size()) begin
        n_checks++;
        if (mon_q[i] !== {(i == 3) ? 1'b1 : 1'b0, 32'h60 + 32'(i)})
          $display("FAIL bp_beat[%0d]: got %h want %h", i, mon_q[i], {(i == 3) ? 1'b1 : 1'b0, 32'h60 + 32'(i)});
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    src_valid[2] = 1'b1;
    src_data[2]  = 32'h70;
    src_last[2]  = 1'b0;
    cyc();
    cyc();
    src_data[2] = 32'h71;
    cyc();
    src_data[2] = 32'h72;
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    src_valid[2] = 1'b0;
    n_checks++; if (m_valid !== 1'b0) $display("FAIL midrst_mvalid: got %b want 0", m_valid); else n_pass++;
    n_checks++; if (grant !== 4'b0000) $display("FAIL midrst_grant: got %b want 0000", grant); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else n_pass++;
    src_valid[1] = 1'b1;
    src_data[1]  = 32'h80;
    src_last[1]  = 1'b1;
    src_valid[3] = 1'b1;
    src_data[3]  = 32'h90;
    src_last[3]  = 1'b1;
    cyc();
    n_checks++; if (grant !== 4'b0010) $display("FAIL midrst_regrant: got %b want 0010", grant); else n_pass++;
    src_valid[1] = 1'b0;
    src_valid[3] = 1'b0;
    do_reset();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      src_data[i]  = '0;
      src_valid[i] = 1'b0;
      src_last[i]  = 1'b0;
      src_keep[i]  = 4'hF >> i;
      src_user[i]  = UW'(i + 9);
    end
    test_reset();
    test_single_source();
    test_arbitration();
    test_packet_atomic();
    test_backpressure();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ltssm_os_arbiter.md
LTSSM_OS_ARBITER -- requirements
Module: ltssm_os_arbiter

Interface
REQ-001 Parameters (name, default, meaning):
- NUM_REQ, 4: ordered-set sources (detect, polling, config, recovery).
- DATA_WIDTH, 32: AXIS data width.
- KEEP_WIDTH, DATA_WIDTH/8: AXIS keep width.
- USER_WIDTH, $bits(phy_user_t): AXIS user width.

REQ-002 Ports (name, direction, width, meaning):
- clk_i, in, 1: the only clock.
- rst_i, in, 1: reset, synchronous, active-high.
- s_axis_tdata_i, in, [NUM_REQ][DATA_WIDTH]: source data.
- s_axis_tkeep_i, in, [NUM_REQ][KEEP_WIDTH]: source keep.
- s_axis_tvalid_i, in, [NUM_REQ]: source valid.
- s_axis_tlast_i, in, [NUM_REQ]: source last beat of the ordered set.
- s_axis_tuser_i, in, [NUM_REQ][USER_WIDTH]: source user.
- s_axis_tready_o, out, [NUM_REQ]: per-source ready.
- m_axis_tdata_o, out, DATA_WIDTH: data toward the PHY TX.
- m_axis_tkeep_o, out, KEEP_WIDTH: keep toward the PHY TX.
- m_axis_tvalid_o, out, 1: valid toward the PHY TX.
- m_axis_tlast_o, out, 1: last toward the PHY TX.
- m_axis_tuser_o, out, USER_WIDTH: user toward the PHY TX.
- m_axis_tready_i, in, 1: PHY TX ready.
- grant_o, out, [NUM_REQ]: one-hot current owner; all zero when idle.
- busy_o, out, 1: a packet is in progress.

Function
REQ-003 The state machine SHALL have exactly two states, ST_IDLE and ST_BUSY.
REQ-004 In ST_IDLE, when any s_axis_tvalid_i bit is 1, the block SHALL select the winner per REQ-009, register it into grant_o, and enter ST_BUSY on the next edge. No source beat SHALL be accepted in the ST_IDLE cycle (one-cycle arbitration bubble).
REQ-005 In ST_BUSY:
- s_axis_tready_o[g] SHALL be (!m_axis_tvalid_o || m_axis_tready_i), where g is the granted source.
- All non-granted ready bits SHALL be 0.
REQ-006 An accepted source beat SHALL load the output register on the next edge, giving one-cycle latency. All five m_axis fields SHALL be copied unchanged, and m_axis_tvalid_o SHALL be set to 1.
REQ-007 m_axis_tvalid_o SHALL clear after an output handshake only if no new beat loads in the same cycle. Simultaneous drain and load SHALL sustain full throughput with no bubble.
REQ-008 Acceptance of a granted beat with tlast=1 SHALL:
- return the block to ST_IDLE;
- clear grant_o and busy_o on the next edge;
- advance the round-robin pointer to g+1 mod NUM_REQ.
REQ-009 Winner selection SHALL be round-robin: the first requesting index at or after the pointer, wrapping from NUM_REQ-1 to 0.
REQ-010 Arbitration SHALL be packet-atomic. Once granted, a source SHALL keep ownership until its tlast beat is accepted, regardless of tvalid gaps or other requests.
REQ-011 A held output beat (m_axis_tvalid_o=1, m_axis_tready_i=0) SHALL NOT block a new arbitration. The newly granted source SHALL receive ready only once that beat drains.
REQ-012 busy_o SHALL equal (state == ST_BUSY).
REQ-013 A single-beat packet (tlast on the first beat) SHALL be supported. Back-to-back packets from one source SHALL cost one idle cycle each.

Reset
REQ-014 Reset SHALL be synchronous and active-high on rst_i, sampled on clk_i.
REQ-015 Reset values:
- state: ST_IDLE; pointer: 0.
- m_axis_tvalid_o, grant_o, busy_o, s_axis_tready_o: 0.
- m_axis data, keep, last and user registers: not reset (don't-care while valid is low).
REQ-016 Reset asserted mid-packet SHALL:
- discard the in-flight beat;
- drop m_axis_tvalid_o on the next edge;
- leave the source to restart its ordered set after reset.

Configuration
REQ-017 With macro LTSSM_ARB_FIXED_PRIO_EN defined, selection SHALL be fixed priority: the lowest requesting index wins and the pointer SHALL be unused (held at 0). Without the macro, round-robin per REQ-009 SHALL apply.

Structure
REQ-018 The arbiter state enum SHALL reside in pcie_phy_pkg alongside phy_user_t. NUM_REQ SHALL remain a module parameter.
REQ-019 Winner selection SHALL be a purely combinational sub-module, ltssm_rr_arb, taking request, pointer and a mode input and producing a one-hot grant.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Source 1 alone sends a 4-beat TS1 (tdata 0xA0..0xA3), m_axis_tready_i=1 -> grant_o=0010 one cycle after request; beats appear one cycle after acceptance, tlast on 0xA3; busy_o drops after tlast.
- Sources 0 and 2 request simultaneously, pointer=0, round-robin -> 0 served first, then 2; with both re-requesting -> 2 does not repeat before 0 (order 0, 2, 0).
- Same case with LTSSM_ARB_FIXED_PRIO_EN -> source 0 always wins while requesting; source 2 starves.
- Granted source 3 stalls tvalid for 5 cycles mid-packet while source 0 requests -> grant holds at 1000 until 3's tlast; source 0 never sees ready.
- m_axis_tready_i toggles 1010... during a 4-beat packet -> no beat lost or duplicated; order preserved; m_axis_tvalid_o stays 1 while a beat is held.
- rst_i pulsed for 1 cycle on beat 2 -> m_axis_tvalid_o=0, grant_o=0 next cycle; the next request is granted normally with pointer=0.
